// File: rtl/noc_pkg.sv
// Shared NoC definitions for the egress stage: geometry, flit layout,
// flit type encoding, FSM states and the round-robin pick helper.
package noc_pkg;

    localparam int AXI_D_WIDTH = 24;
    localparam int VID_BITS    = 6;
    localparam int TYPE_BITS   = 2;
    localparam int D_WIDTH     = TYPE_BITS + VID_BITS + AXI_D_WIDTH;
    localparam int NUM_VC      = 12;
    localparam int BUF_DEPTH   = 12;
    localparam int CNT_BITS    = $clog2(BUF_DEPTH + 1);
    localparam int VC_BITS     = $clog2(NUM_VC);
    localparam int VC_SUM_BITS = VC_BITS + 1;

    // Flit field positions inside the D_WIDTH word
    localparam int TYPE_LSB    = AXI_D_WIDTH + VID_BITS;
    localparam int VID_LSB     = AXI_D_WIDTH;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic [TYPE_BITS-1:0] {
        BODY     = 2'b00,
        HEAD     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e                 ftype;
        logic [VID_BITS-1:0]        vid;
        logic [AXI_D_WIDTH-1:0]     payload;
    } flit_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_STREAM = 2'b01
    } egress_state_e;

    // A flit closes a packet when it is a TAIL or a single-flit HEADTAIL
    function automatic logic is_tail(input flit_type_e t);
        return (t == TAIL) || (t == HEADTAIL);
    endfunction

    // Lowest requesting VC at or after ptr (mod NUM_VC); MSB of result = hit
    function automatic logic [VC_BITS:0] rr_pick(input logic [NUM_VC-1:0] req,
                                                 input logic [VC_BITS-1:0] ptr);
        logic [VC_BITS:0]   res;
        logic [VC_BITS:0]   sum;
        logic [VC_BITS-1:0] idx;
        res = {VC_SUM_BITS{1'b0}};
        // Walk from the farthest offset down so the nearest request wins last
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + VC_SUM_BITS'(i);
            if (sum >= VC_SUM_BITS'(NUM_VC)) begin
                idx = VC_BITS'(sum - VC_SUM_BITS'(NUM_VC));
            end else begin
                idx = sum[VC_BITS-1:0];
            end
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tl_egress_if.sv
// Egress port bundle: flit input from the switch, credit return,
// AXI stream output and sticky error flags.
interface tl_egress_if;
    import noc_pkg::*;

    logic [D_WIDTH-1:0]     flit_in;
    logic                   flit_valid;
    logic [NUM_VC-1:0]      credit_out;
    logic [AXI_D_WIDTH-1:0] out_tdata;
    logic                   out_tvalid;
    logic                   out_tlast;
    logic                   out_tready;
    logic                   err_overflow;
    logic                   err_badvid;

    // The egress block itself
    modport slave (
        input  flit_in, flit_valid, out_tready,
        output credit_out, out_tdata, out_tvalid, out_tlast, err_overflow, err_badvid
    );

    // The surrounding router / stream sink
    modport master (
        output flit_in, flit_valid, out_tready,
        input  credit_out, out_tdata, out_tvalid, out_tlast, err_overflow, err_badvid
    );
endinterface

// File: rtl/egress_vc_fifo.sv
// Per-VC first-word-fall-through flit buffer with occupancy and a count
// of complete packets resident in the buffer.
module egress_vc_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int CW    = CNT_BITS
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  flit_t         i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_pkt_cnt,
    output flit_t         o_head
);
    localparam int PW = $clog2(DEPTH);

    flit_t          r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_pkt_cnt;
    logic           w_do_push;
    logic           w_do_pop;
    logic           w_push_tail;
    logic           w_pop_tail;

    // Depth need not be a power of two, so pointers wrap explicitly
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
    endfunction

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == CW'(0));
    assign o_count     = r_count;
    assign o_pkt_cnt   = r_pkt_cnt;
    assign o_head      = r_mem[r_rd_ptr];

    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !o_empty;
    assign w_push_tail = w_do_push && is_tail(i_data.ftype);
    assign w_pop_tail  = w_do_pop && is_tail(o_head.ftype);

    // Storage array: written on push, no reset needed (guarded by count)
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and resident-packet count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= PW'(0);
            r_rd_ptr  <= PW'(0);
            r_count   <= CW'(0);
            r_pkt_cnt <= CW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            case ({w_push_tail, w_pop_tail})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + CW'(1);
                2'b01:   r_pkt_cnt <= r_pkt_cnt - CW'(1);
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

endmodule

// File: rtl/tl_egress_chk.sv
// Invariant checker for the egress stage: the selected VC is never empty
// while streaming, occupancy stays bounded, and credits are one-hot.
module tl_egress_chk
    import noc_pkg::*;
(
    input logic                clk,
    input logic                rst,
    input logic                i_streaming,
    input logic                i_sel_empty,
    input logic [CNT_BITS-1:0] i_sel_count,
    input logic [NUM_VC-1:0]   i_credit
);

    a_stream_not_empty: assert property (@(posedge clk) disable iff (!rst)
        i_streaming |-> !i_sel_empty);

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst)
        i_sel_count <= CNT_BITS'(BUF_DEPTH));

    a_credit_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(i_credit));

endmodule

// File: rtl/tl_egress.sv
// Transport-layer egress: filters incoming flits, buffers them per VC,
// picks complete packets round-robin and streams each one uninterleaved
// on AXI stream, returning one credit per freed slot.
module tl_egress
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    tl_egress_if.slave bus
);

    flit_t                 w_flit;
    logic                  w_vid_ok;
    logic [VC_BITS-1:0]    w_vid_idx;
    logic                  w_overflow_hit;
    logic                  w_badvid_hit;
    logic [NUM_VC-1:0]     w_push;
    logic [NUM_VC-1:0]     w_pop;
    logic [NUM_VC-1:0]     w_full;
    logic [NUM_VC-1:0]     w_empty;
    logic [NUM_VC-1:0]     w_req;
    logic [CNT_BITS-1:0]   w_count   [NUM_VC];
    logic [CNT_BITS-1:0]   w_pkt_cnt [NUM_VC];
    flit_t                 w_head    [NUM_VC];
    flit_t                 w_head_sel;
    logic                  w_head_last;
    logic [VC_BITS:0]      w_pick;

    egress_state_e         r_state;
    egress_state_e         w_state_nxt;
    logic [VC_BITS-1:0]    r_sel;
    logic [VC_BITS-1:0]    w_sel_nxt;
    logic [VC_BITS-1:0]    r_rr_ptr;
    logic [VC_BITS-1:0]    w_rr_nxt;
    logic                  w_pop_go;
    logic                  w_streaming;
    logic [NUM_VC-1:0]     r_credit;
    logic                  r_err_overflow;
    logic                  r_err_badvid;

    // ---------------- input filtering ----------------
    assign w_flit         = flit_t'(bus.flit_in);
    assign w_vid_ok       = (w_flit.vid < VID_BITS'(NUM_VC));
    assign w_vid_idx      = w_flit.vid[VC_BITS-1:0];
    assign w_badvid_hit   = bus.flit_valid && !w_vid_ok;
    assign w_overflow_hit = bus.flit_valid && w_vid_ok && w_full[w_vid_idx];
    assign w_push         = (bus.flit_valid && w_vid_ok && !w_full[w_vid_idx])
                          ? (NUM_VC'(1) << w_vid_idx) : NUM_VC'(0);

    // ---------------- per-VC buffers ----------------
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        egress_vc_fifo #(
            .DEPTH (BUF_DEPTH),
            .CW    (CNT_BITS)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_push    (w_push[v]),
            .i_data    (w_flit),
            .i_pop     (w_pop[v]),
            .o_full    (w_full[v]),
            .o_empty   (w_empty[v]),
            .o_count   (w_count[v]),
            .o_pkt_cnt (w_pkt_cnt[v]),
            .o_head    (w_head[v])
        );
        assign w_req[v] = (w_pkt_cnt[v] != CNT_BITS'(0));
    end

    assign w_pick      = rr_pick(w_req, r_rr_ptr);
    assign w_head_sel  = w_head[r_sel];
    assign w_head_last = is_tail(w_head_sel.ftype);
    assign w_streaming = (r_state == S_STREAM);
    assign w_pop       = w_pop_go ? (NUM_VC'(1) << r_sel) : NUM_VC'(0);

    // FSM state, selected VC and round-robin pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_sel    <= VC_BITS'(0);
            r_rr_ptr <= VC_BITS'(0);
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // FSM next state: pick a complete packet, then stream it to its tail
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_rr_nxt    = r_rr_ptr;
        w_pop_go    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick[VC_BITS]) begin
                    w_state_nxt = S_STREAM;
                    w_sel_nxt   = w_pick[VC_BITS-1:0];
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STREAM: begin
                w_pop_go = bus.out_tready;
                if (bus.out_tready && w_head_last) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = (r_sel == VC_BITS'(NUM_VC - 1)) ? VC_BITS'(0)
                                                                  : r_sel + VC_BITS'(1);
                end else begin
                    w_state_nxt = S_STREAM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Credit return (one cycle after each pop) and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit       <= NUM_VC'(0);
            r_err_overflow <= 1'b0;
            r_err_badvid   <= 1'b0;
        end else begin
            r_credit       <= w_pop;
            r_err_overflow <= r_err_overflow | w_overflow_hit;
            r_err_badvid   <= r_err_badvid | w_badvid_hit;
        end
    end

    // Stream outputs decode from the state register; data is the FWFT head,
    // forced to zero while idle so the bus is quiet between packets
    assign bus.out_tvalid   = w_streaming;
    assign bus.out_tdata    = w_streaming ? w_head_sel.payload : AXI_D_WIDTH'(0);
    assign bus.out_tlast    = w_streaming && w_head_last;
    assign bus.credit_out   = r_credit;
    assign bus.err_overflow = r_err_overflow;
    assign bus.err_badvid   = r_err_badvid;

    tl_egress_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_streaming (w_streaming),
        .i_sel_empty (w_empty[r_sel]),
        .i_sel_count (w_count[r_sel]),
        .i_credit    (r_credit)
    );

endmodule

// File: doc/tl_egress.md
Name: tl_egress

Overview:
- Transport-layer egress stage at the local ejection port of a router; counterpart of the ingress interface.
- Accepts flits from the switch output, buffers them per virtual channel, and rebuilds whole packets.
- Emits each packet uninterleaved on an AXI stream master.
- Returns one credit per freed buffer slot to the upstream VC allocator.

Parameters:
AXI_D_WIDTH, 24, AXI stream payload width
D_WIDTH, 32, flit width; must equal TYPE_BITS + VID_BITS + AXI_D_WIDTH
VID_BITS, 6, VC id field width in flit
TYPE_BITS, 2, flit type field width
NUM_VC, 12, local ejection VCs
BUF_DEPTH, 12, flits per VC buffer
CNT_BITS, $clog2(BUF_DEPTH+1), occupancy/packet counter width (localparam)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (asserted at 0)
flit_in  in  D_WIDTH  flit {type[31:30], vid[29:24], payload[23:0]}
flit_valid  in  1  flit_in valid this cycle; no backpressure (credit-based)
credit_out  out  NUM_VC  one-cycle pulse per VC when a slot is freed
out_tdata  out  AXI_D_WIDTH  flit payload
out_tvalid  out  1  AXI valid
out_tlast  out  1  high on the tail flit of a packet
out_tready  in  1  AXI ready
err_overflow  out  1  sticky: flit arrived for a full VC
err_badvid  out  1  sticky: vid >= NUM_VC

Behaviour:
- Reset (rst=0, async): all FIFOs empty, pkt_cnt=0, rr_ptr=0, state=IDLE, all outputs 0. Deassertion is synchronous to clk.
- Flit types: 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL (single-flit packet).
- Write: on flit_valid with vid < NUM_VC and FIFO[vid] not full, push the flit; it is visible at N+1.
  - TAIL or HEADTAIL increments pkt_cnt[vid] at N+1.
- Bad vid: flit dropped, err_badvid set at N+1.
- Full FIFO: flit dropped, err_overflow set at N+1, no state change.
- Error flags clear only on reset.
- FSM IDLE:
  - Round-robin pick of the lowest v at or after rr_ptr (mod NUM_VC) with pkt_cnt[v] > 0.
  - On a hit: sel <= v, state <= STREAM.
  - Minimum latency: flit written at N, out_tvalid at N+2.
- FSM STREAM:
  - out_tvalid=1; out_tdata and out_tlast are driven from the FIFO[sel] head (first-word fall-through).
  - out_tlast = (head type is TAIL or HEADTAIL).
  - Pop on out_tvalid & out_tready.
  - Tail pop: pkt_cnt[sel] decrements, rr_ptr <= (sel+1) mod NUM_VC, state <= IDLE.
  - Back-to-back packets on separate VCs therefore have a 1-cycle bubble.
- AXI rule: once out_tvalid is high, out_tdata, out_tlast and out_tvalid hold until out_tready. out_tvalid never depends on out_tready.
- Credits: every pop pulses credit_out[sel] at pop+1 (registered). At most one bit is set per cycle.
- Simultaneous push and pop on the same VC: both happen, occupancy unchanged.
- Simultaneous tail push and tail pop on the same VC: pkt_cnt unchanged.
- Because whole packets are resident before selection, STREAM never sees an empty FIFO[sel]. This is an assertion, not a handled case.
- Counter arithmetic is unsigned CNT_BITS, with no wrap: occupancy is at most BUF_DEPTH.

Decomposition:
- Shared package noc_pkg holds:
  - flit_type_e (BODY, HEAD, TAIL, HEADTAIL)
  - flit field offsets/widths
  - flit_t packed struct {type, vid, payload}
- Sub-module egress_vc_fifo is instantiated NUM_VC times. It is a FWFT FIFO with push, pop, full, empty, count and head data, plus its own pkt_cnt.
- The top level holds the bad-vid/overflow filtering, RR arbiter, FSM and credit registers.

Test Plan:
- HEADTAIL flit vid=3 payload 0xABCDEF, out_tready=1 -> out_tvalid at N+2 with tdata=0xABCDEF, tlast=1; credit_out=12'h008 one cycle later.
- 4-flit packet on vid=5 with out_tready low for 3 cycles mid-packet -> tdata/tlast stable while stalled; 4 beats, tlast on beat 4 only; 4 credit pulses on bit 5.
- Complete packets present on VCs 2, 7 and 11 at once, rr_ptr=0 -> emitted in order 2, 7, 11, each uninterleaved; next rr_ptr=0.
- 13 flits pushed to vid=0 with no tail and the stream stalled -> first 12 stored, 13th dropped, err_overflow=1, no output.
- Flit with vid=12 -> dropped, err_badvid=1, no credit, outputs idle.
- rst driven low mid-packet (beat 2 of 4) -> out_tvalid=0 and credit_out=0 immediately (async); after release, FIFOs empty and state IDLE.
